instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Front end of the IF stage: owns the PC, issues requests to instruction memory, and drives the
//  IF->ID pipeline register. It delivers one instruction/address pair per accepted fetch.
//  It inserts NOP bubbles on memory wait states and jump flushes, and freezes on pipeline hold.
//  Handles variable-latency memory, jump redirect from EX, and hold from the hazard controller.
// PARAMETERS
//  RESET_ADDR  32'h0000_0000  PC value after reset
//  INST_NOP    32'h0000_0013  bubble instruction (addi x0,x0,0)
//  ADDR_STEP   4              PC increment per accepted instruction
// PORTS
//  sys_clk_i           in   1   clock, rising edge
//  rst_n_i             in   1   asynchronous active-low reset
//  jump_en_i           in   1   redirect request from EX (single-cycle pulse)
//  jump_addr_i         in   32  redirect target
//  hold_i              in   1   stall from hazard control; freeze IF->ID outputs
//  imem_req_o          out  1   instruction memory request (level)
//  imem_addr_o         out  32  fetch address; stable while imem_req_o=1
//  imem_ack_i          in   1   memory data valid (one-cycle pulse per request)
//  imem_rdata_i        in   32  instruction word, valid when imem_ack_i=1
//  instruction_addr_o  out  32  registered address of instruction_o
//  instruction_o       out  32  registered instruction to IF->ID
//  instruction_valid_o out  1   1 = instruction_o is a real fetched instruction
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_ADDR, buf empty, imem_req_o=0, instruction_o=INST_NOP,
//   instruction_addr_o=0, instruction_valid_o=0. imem_req_o=(state==FETCH), imem_addr_o=pc (comb).
//  States: IDLE, FETCH, BUFFERED, DRAIN.
//   IDLE: next cycle -> FETCH (one bubble after reset release).
//   FETCH: request outstanding; addr held until ack. Ack may arrive same cycle as req (0-wait) or later.
//    ack & !hold & !jump: outputs <= {pc, rdata, valid=1}; pc += ADDR_STEP; stay FETCH.
//    ack & hold & !jump: rdata,pc -> buf; outputs frozen; -> BUFFERED.
//    !ack & !hold: outputs <= INST_NOP, valid=0, addr unchanged (bubble).
//    !ack & hold: outputs frozen.
//   BUFFERED: imem_req_o=0. When !hold: outputs <= buf, valid=1; pc += ADDR_STEP; -> FETCH.
//   DRAIN: imem_req_o=0; waits for ack of a cancelled request, discards data.
//    Then pc=target, -> FETCH.
//  Jump (priority over hold and ack, any state): outputs <= INST_NOP, valid=0 (flush, even if hold).
//   Buffer cleared. Target latched.
//   FETCH with ack same cycle: data dropped; pc=jump_addr_i; stay FETCH.
//   FETCH without ack: -> DRAIN; imem_addr_o not changed while the old request is unacked.
//   DRAIN: a new jump overwrites the latched target. IDLE/BUFFERED: pc=jump_addr_i; -> FETCH.
//  Arithmetic: pc 32-bit unsigned, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment check.
//  Ack while not in FETCH/DRAIN is ignored. Reset mid-request: all state lost; memory reset too.
//  Latency: ack at edge N -> instruction_o valid after edge N (1 cycle registered).
//  Throughput 1 instr/cycle with 0-wait memory.
// TESTING
//  1 Reset release, 0-wait memory returning word=addr -> 1 bubble.
//    Then addrs 0,4,8.. valid each cycle; instruction_o=32'h0,4,8.
//  2 Memory 2 wait states -> each valid instruction separated by 2 NOP bubbles (valid=0);
//    imem_addr_o stable.
//  3 hold_i=1 on cycle of ack at addr 8 -> outputs frozen on addr 4.
//    Release -> addr 8 out with valid=1, no refetch.
//  4 jump_en_i with jump_addr_i=32'h100 while request for 0x10 pending (ack 2 cycles later)
//    -> 0x10 data discarded. Next request is 0x100; no valid 0x10 output.
//  5 jump same cycle as ack and hold_i=1 -> instruction_o=INST_NOP, valid=0. Next fetch at target.
//  6 RESET_ADDR=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
//    Async reset mid-FETCH -> outputs at reset values immediately.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
// A request is held at a stable address until the memory answers with a single-cycle ack.
interface instruction_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF-stage front end: owns the PC, fetches from instruction memory and drives the IF->ID register.
// Inserts NOP bubbles on wait states and jump flushes; freezes its outputs while hold_i is set.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] INST_NOP   = 32'h0000_0013,
  parameter logic [31:0] ADDR_STEP  = 32'd4
) (
  input  logic                           sys_clk_i,
  input  logic                           rst_n_i,
  input  logic                           jump_en_i,
  input  logic [31:0]                    jump_addr_i,
  input  logic                           hold_i,
  instruction_fetch_unit_if.master       imem,
  output logic [31:0]                    instruction_addr_o,
  output logic [31:0]                    instruction_o,
  output logic                           instruction_valid_o
);

  typedef enum logic [1:0] {IDLE, FETCH, BUFFERED, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_valid_q, out_valid_d;

  assign imem.req            = (state_q == FETCH);
  assign imem.addr           = pc_q;
  assign instruction_addr_o  = out_addr_q;
  assign instruction_o       = out_inst_q;
  assign instruction_valid_o = out_valid_q;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    buf_inst_d  = buf_inst_q;
    out_addr_d  = out_addr_q;
    out_inst_d  = out_inst_q;
    out_valid_d = out_valid_q;

    if (jump_en_i) begin
      // Redirect wins over hold and ack: flush the IF->ID register unconditionally.
      out_inst_d  = INST_NOP;
      out_valid_d = 1'b0;
      target_d    = jump_addr_i;
      unique case (state_q)
        FETCH: begin
          if (imem.ack) pc_d = jump_addr_i;
          else          state_d = DRAIN;  // old request still owns imem.addr
        end
        DRAIN: begin
          if (imem.ack) begin
            pc_d    = jump_addr_i;
            state_d = FETCH;
          end
        end
        default: begin
          pc_d    = jump_addr_i;
          state_d = FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
          if (!hold_i) begin
            out_inst_d  = INST_NOP;
            out_valid_d = 1'b0;
          end
        end
        FETCH: begin
          if (imem.ack && hold_i) begin
            // Park the word; pc stays put so it doubles as the buffered address.
            buf_inst_d = imem.rdata;
            state_d    = BUFFERED;
          end else if (imem.ack) begin
            out_addr_d  = pc_q;
            out_inst_d  = imem.rdata;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_STEP;
          end else if (!hold_i) begin
            out_inst_d  = INST_NOP;
            out_valid_d = 1'b0;
          end
        end
        BUFFERED: begin
          if (!hold_i) begin
            out_addr_d  = pc_q;
            out_inst_d  = buf_inst_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_STEP;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          if (imem.ack) begin
            pc_d    = target_q;
            state_d = FETCH;
          end
          if (!hold_i) begin
            out_inst_d  = INST_NOP;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_ADDR;
      target_q    <= RESET_ADDR;
      buf_inst_q  <= INST_NOP;
      out_addr_q  <= 32'h0;
      out_inst_q  <= INST_NOP;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      buf_inst_q  <= buf_inst_d;
      out_addr_q  <= out_addr_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized phase,
// all judged by a program-order reference model and a variable-latency memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        hold = 1'b0;
  logic [31:0] inst_addr, inst;
  logic        inst_valid;
  logic [31:0] w_addr, w_inst;
  logic        w_valid;

  int n_cmp = 0;
  int n_err = 0;

  instruction_fetch_unit_if imem0 ();
  instruction_fetch_unit_if imem1 ();

  instruction_fetch_unit dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .jump_en_i(jump_en), .jump_addr_i(jump_addr),
    .hold_i(hold), .imem(imem0), .instruction_addr_o(inst_addr), .instruction_o(inst),
    .instruction_valid_o(inst_valid));

  instruction_fetch_unit #(.RESET_ADDR(32'hFFFF_FFFC)) dut_w (
    .sys_clk_i(clk), .rst_n_i(rst_n), .jump_en_i(1'b0), .jump_addr_i(32'h0),
    .hold_i(1'b0), .imem(imem1), .instruction_addr_o(w_addr), .instruction_o(w_inst),
    .instruction_valid_o(w_valid));

  always #5 clk = ~clk;

  // Zero-wait memory for the wrap-around instance: word equals its address.
  assign imem1.ack   = imem1.req;
  assign imem1.rdata = imem1.addr;

  // Variable-latency memory: accepts a request, answers after pend_lat cycles even if req drops.
  int unsigned lat = 0;
  int unsigned pend_lat = 0;
  int unsigned wcnt = 0;
  logic        pending = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] key = 32'h0;
  int          ack_count = 0;
  logic        mem_ack;

  always_comb mem_ack = pending ? (wcnt >= pend_lat) : (imem0.req && lat == 0);
  assign imem0.ack   = mem_ack;
  assign imem0.rdata = (pending ? pend_addr : imem0.addr) ^ key;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      wcnt      <= 0;
      pend_addr <= 32'h0;
      pend_lat  <= 0;
    end else begin
      if (mem_ack) ack_count <= ack_count + 1;
      if (pending) begin
        if (mem_ack) pending <= 1'b0;
        else         wcnt <= wcnt + 1;
      end else if (imem0.req && !mem_ack) begin
        pending   <= 1'b1;
        pend_addr <= imem0.addr;
        pend_lat  <= lat;
        wcnt      <= 1;
      end
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: valid outputs must follow program order from the reset address,
  // restarting at each jump target; data is the memory word for that address.
  logic [31:0] s_addr, s_inst, s_jaddr;
  logic        s_valid, s_jump, s_hold;
  logic        s_ok = 1'b0;
  logic [31:0] exp_next = 32'h0;
  int          deliveries = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_ok     = 1'b0;
      exp_next = 32'h0;
    end else begin
      if (s_ok) begin
        if (s_jump) begin
          check("flush", {inst_valid, inst}, {1'b0, NOP});
          exp_next = s_jaddr;
        end else if (s_hold) begin
          check("hold freeze", {inst_addr, inst, inst_valid}, {s_addr, s_inst, s_valid});
        end else if (inst_valid) begin
          check("order addr", inst_addr, exp_next);
          check("order data", inst, inst_addr ^ key);
          exp_next   = exp_next + 32'd4;
          deliveries++;
        end else begin
          check("bubble", {inst_addr, inst}, {s_addr, NOP});
        end
      end
      if (pending) check("req addr stable", imem0.addr, pend_addr);
      s_addr  = inst_addr;
      s_inst  = inst;
      s_valid = inst_valid;
      s_jump  = jump_en;
      s_jaddr = jump_addr;
      s_hold  = hold;
      s_ok    = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    jump_en = 1'b0;
    hold    = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!inst_valid && n < budget);
    check(tag, n < budget, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    int          cnt0;

    // 1: reset values, one bubble, then 0-wait stream word=addr.
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    check("rst valid", inst_valid, 1'b0);
    check("rst inst", inst, NOP);
    check("rst addr", inst_addr, 32'h0);
    check("rst req", imem0.req, 1'b0);
    rst_n = 1'b1;
    cyc();
    check("first bubble", {inst_valid, inst}, {1'b0, NOP});
    check("first req", {imem0.req, imem0.addr}, {1'b1, 32'h0});
    check("wrap bubble", w_valid, 1'b0);
    cyc();
    check("t1 addr0", {inst_valid, inst_addr, inst}, {1'b1, 32'h0, 32'h0});
    check("wrap first", {w_valid, w_addr, w_inst}, {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC});
    cyc();
    check("wrap second", {w_valid, w_addr, w_inst}, {1'b1, 32'h0, 32'h0});
    check("t1 addr4", {inst_valid, inst_addr, inst}, {1'b1, 32'h4, 32'h4});
    for (int i = 2; i < 4; i++) begin
      cyc();
      check("t1 stream", {inst_valid, inst_addr, inst}, {1'b1, 32'(4 * i), 32'(4 * i)});
    end

    // 2: two wait states -> two bubbles between valid instructions.
    lat = 2;
    wait_valid("t2 first timeout", 10);
    for (int r = 0; r < 2; r++) begin
      a = imem0.addr;
      cyc();
      check("t2 bubble1", inst_valid, 1'b0);
      check("t2 addr hold1", imem0.addr, a);
      cyc();
      check("t2 bubble2", inst_valid, 1'b0);
      check("t2 addr hold2", imem0.addr, a);
      cyc();
      check("t2 valid", {inst_valid, inst_addr}, {1'b1, a});
    end

    // 3: hold on the ack cycle of addr 8 -> frozen on 4, then 8 without refetch.
    lat = 0;
    do_reset();
    cyc();
    cyc();
    cyc();
    check("t3 addr4", {inst_valid, inst_addr}, {1'b1, 32'h4});
    cnt0 = ack_count;
    hold = 1'b1;
    cyc();
    check("t3 frozen", {inst_valid, inst_addr, inst}, {1'b1, 32'h4, 32'h4});
    check("t3 no req buffered", imem0.req, 1'b0);
    cyc();
    check("t3 still frozen", {inst_valid, inst_addr}, {1'b1, 32'h4});
    hold = 1'b0;
    cyc();
    check("t3 addr8", {inst_valid, inst_addr, inst}, {1'b1, 32'h8, 32'h8});
    check("t3 no refetch", ack_count, cnt0 + 1);

    // 4: jump while the request for 0x10 is pending -> 0x10 discarded, next request 0x100.
    cyc();
    check("t4 addr12", {inst_valid, inst_addr}, {1'b1, 32'hC});
    lat       = 2;
    jump_en   = 1'b1;
    jump_addr = 32'h100;
    cyc();
    jump_en = 1'b0;
    check("t4 flush", {inst_valid, inst}, {1'b0, NOP});
    check("t4 old addr kept", imem0.addr, 32'h10);
    cyc();
    check("t4 drain valid", inst_valid, 1'b0);
    check("t4 drain addr", {imem0.req, imem0.addr}, {1'b0, 32'h10});
    cyc();
    check("t4 no 0x10", inst_valid, 1'b0);
    check("t4 new req", {imem0.req, imem0.addr}, {1'b1, 32'h100});
    lat = 0;
    cyc();
    check("t4 target out", {inst_valid, inst_addr, inst}, {1'b1, 32'h100, 32'h100});

    // 5: jump with ack and hold in the same cycle -> flush, next fetch at target.
    hold      = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 32'h200;
    cyc();
    hold    = 1'b0;
    jump_en = 1'b0;
    check("t5 flush", {inst_valid, inst}, {1'b0, NOP});
    check("t5 req target", {imem0.req, imem0.addr}, {1'b1, 32'h200});
    cyc();
    check("t5 target out", {inst_valid, inst_addr}, {1'b1, 32'h200});

    // 6: async reset mid-request -> reset values immediately.
    lat = 2;
    cyc();
    #3 rst_n = 1'b0;
    #1;
    check("t6 async valid", {inst_valid, inst, inst_addr}, {1'b0, NOP, 32'h0});
    check("t6 async req", imem0.req, 1'b0);
    check("t6 async wrap", {w_valid, w_inst, w_addr}, {1'b0, NOP, 32'h0});
    cyc();
    rst_n = 1'b1;

    // Randomized phase, judged by the reference model.
    key = $urandom;
    do_reset();
    deliveries = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      jump_en   = ($urandom_range(0, 19) == 0);
      jump_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      hold      = ($urandom_range(0, 3) == 0);
      lat       = $urandom_range(0, 3);
    end
    jump_en = 1'b0;
    hold    = 1'b0;
    repeat (8) cyc();
    check("liveness", deliveries >= 50, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
